ps2_transmitter: RTL and testbench
==================================

// Module: ps2_transmitter
// PURPOSE
//   Host-to-device PS/2 sender: sends one command byte (e.g. 0xFF reset, 0xED LEDs) to keyboard/mouse.
//   Sits beside ps2_receiver on the same open-drain ps2_clk/ps2_data pins.
//   Drives lines only through active-high output enables (pin driven 0 when enabled, pulled up otherwise).
//   Top level arbitrates the pins; receiver must ignore the lines while busy=1.
// PARAMETERS
//   INHIBIT_CYCLES  1600    clk cycles ps2_clk held low before request-to-send (100 us @ 16 MHz)
//   TIMEOUT_CYCLES  240000  max clk cycles from RTS to ACK before abort (15 ms @ 16 MHz)
//   FILTER_LEN      5       consecutive equal samples needed to accept a ps2_clk level
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  1-cycle request; sampled only in IDLE
//   tx_data      in   8  byte to send; captured on accepted start
//   ps2_clk_in   in   1  raw ps2_clk pin level (asynchronous)
//   ps2_data_in  in   1  raw ps2_data pin level (asynchronous)
//   ps2_clk_oe   out  1  1 = pull ps2_clk low
//   ps2_data_oe  out  1  1 = pull ps2_data low
//   busy         out  1  high from accepted start until back in IDLE
//   done         out  1  1-cycle pulse: device ACKed and lines returned high
//   error        out  1  1-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//   Reset: state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0; counters cleared.
//   Input conditioning: 2-flop sync on both pins; ps2_clk filtered to clk_f, which changes only after
//     FILTER_LEN equal synced samples. Falling edge fe = clk_f 1->0 (registered, 1 cycle/edge).
//   Capture: on start in IDLE latch tx_data; shift = {1'b1 stop, ~^tx_data odd parity, tx_data}.
//     busy=1 the next cycle.
//   FSM:
//     IDLE     oe both 0. start -> INHIBIT, timer=0.
//     INHIBIT  clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then data_oe=1 (start bit) -> RTS.
//     RTS      data_oe=1 is held; clk_oe=0 (release). bitcnt=0, timeout timer starts -> SEND.
//     SEND     on each fe: data_oe = ~shift[0]; shift>>1; bitcnt++.
//              fe #1..8 = data LSB first, #9 = parity, #10 = stop (data_oe=0).
//              After fe #10 -> ACK.
//     ACK      on fe #11 sample synced data: 0 -> WAIT_IDLE; 1 -> error pulse, -> IDLE.
//     WAIT_IDLE  wait until clk_f=1 and synced data=1 -> done pulse, -> IDLE.
//   Timeout: counter runs RTS..WAIT_IDLE; reaching TIMEOUT_CYCLES in any of those states gives
//     error pulse, both oe=0, -> IDLE. The counter is not reset per bit.
//   done and error are never both high. busy drops the same cycle done/error pulses.
//   start while busy is ignored (no queueing). tx_data changes after capture have no effect.
//   Reset mid-frame: async, both oe released immediately; no done/error pulse.
//   Glitch on ps2_clk shorter than FILTER_LEN cycles: no edge counted.
//   Counters sized by $clog2 of their parameter. bitcnt is 4 bits and saturates at 11.
// TESTING
//   start, tx_data=0xFF; device model clocks 11 bits @ 12.5 kHz and ACKs -> bits seen by device
//     at clk rising edges = 0,1x8,parity 1,stop 1; done=1 once; busy high throughout.
//   tx_data=0xED -> data bits 1,0,1,1,0,1,1,1 LSB first, parity=1 (six 1s -> odd parity=1).
//   tx_data=0x00 -> parity bit 1; tx_data=0x01 -> parity bit 0.
//   Device never clocks after RTS -> error pulse at TIMEOUT_CYCLES after RTS; both oe=0; back in IDLE.
//   Device omits ACK (data high at fe #11) -> error=1, done stays 0.
//   Assert rst_n=0 during bit 4 -> oe outputs 0 asynchronously; a new start afterwards sends
//     the full frame normally.
//   3-cycle low glitch on ps2_clk_in during SEND -> bit count unchanged, frame completes with done.
//   start pulsed while busy -> ignored; only the first byte is transmitted.
//   ps2_clk_oe measured low for exactly INHIBIT_CYCLES cycles before data_oe rises.

Source files
------------

// File: rtl/ps2_transmitter_if.sv
// Command/status handshake and open-drain pin view shared by the host logic and ps2_transmitter.
interface ps2_transmitter_if;
    logic       start;
    logic [7:0] tx_data;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, tx_data, ps2_clk_in, ps2_data_in,
        input  ps2_clk_oe, ps2_data_oe, busy, done, error
    );

    modport slave (
        input  start, tx_data, ps2_clk_in, ps2_data_in,
        output ps2_clk_oe, ps2_data_oe, busy, done, error
    );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 byte sender: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Pins are only pulled low through active-high output enables; the top level arbitrates them.
module ps2_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 1600,
    parameter int unsigned TIMEOUT_CYCLES = 240000,
    parameter int unsigned FILTER_LEN     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_transmitter_if.slave bus
);
    localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned SHIFT_W = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic               r_clk_f, r_clk_f_d, r_fe;
    logic [FLT_W-1:0]   r_flt_cnt;
    logic [INH_W-1:0]   r_inh_cnt, w_inh_cnt_nxt;
    logic [TO_W-1:0]    r_tout_cnt, w_tout_cnt_nxt;
    logic [BIT_W-1:0]   r_bitcnt, w_bitcnt_nxt, w_bitcnt_inc;
    logic [SHIFT_W-1:0] r_shift, w_shift_nxt;
    logic               r_clk_oe, w_clk_oe_nxt;
    logic               r_data_oe, w_data_oe_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic               w_in_frame, w_timeout;

    // Pin synchronisers plus a persistence filter on ps2_clk; lines idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_fe      <= 1'b0;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1  <= bus.ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= bus.ps2_data_in;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            r_fe      <= r_clk_f_d & ~r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                r_clk_f   <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_tout_cnt <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inh_cnt  <= w_inh_cnt_nxt;
            r_tout_cnt <= w_tout_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign w_in_frame   = (r_state == S_RTS) || (r_state == S_SEND) ||
                          (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout    = (r_tout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_bitcnt_inc = (r_bitcnt == BIT_W'(11)) ? r_bitcnt : r_bitcnt + BIT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_inh_cnt_nxt  = r_inh_cnt;
        w_tout_cnt_nxt = r_tout_cnt;
        w_bitcnt_nxt   = r_bitcnt;
        w_shift_nxt    = r_shift;
        w_clk_oe_nxt   = r_clk_oe;
        w_data_oe_nxt  = r_data_oe;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (bus.start) begin
                    w_shift_nxt   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    w_inh_cnt_nxt = '0;
                    w_clk_oe_nxt  = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_data_oe_nxt  = 1'b1;
                    w_tout_cnt_nxt = '0;
                    w_state_nxt    = S_RTS;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
                end
            end
            S_RTS: begin
                w_clk_oe_nxt = 1'b0;
                w_bitcnt_nxt = '0;
                w_state_nxt  = S_SEND;
            end
            S_SEND: begin
                // Start bit is already on the line; each falling edge presents the next bit.
                if (r_fe) begin
                    w_data_oe_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[SHIFT_W-1:1]};
                    w_bitcnt_nxt  = w_bitcnt_inc;
                    if (r_bitcnt == BIT_W'(9)) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (r_fe) begin
                    w_bitcnt_nxt = w_bitcnt_inc;
                    if (!r_dat_s2) begin
                        w_state_nxt = S_WAIT_IDLE;
                    end else begin
                        w_error_nxt   = 1'b1;
                        w_busy_nxt    = 1'b0;
                        w_clk_oe_nxt  = 1'b0;
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_f && r_dat_s2) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // One frame-wide timeout covers RTS through WAIT_IDLE and overrides everything above.
        if (w_in_frame) begin
            w_tout_cnt_nxt = r_tout_cnt + TO_W'(1);
            if (w_timeout) begin
                w_done_nxt    = 1'b0;
                w_error_nxt   = 1'b1;
                w_busy_nxt    = 1'b0;
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        end
    end

    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a PS/2 device model clocks frames out of the DUT, a queue holds
// the expected frame per accepted start, plus hand-written timeout / reset / inhibit cases.
module tb_ps2_transmitter;
    localparam int unsigned INH  = 20;
    localparam int unsigned TOUT = 3000;
    localparam int unsigned FLT  = 5;
    localparam int unsigned HALF = 40;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;     // bit i = i-th bit seen by the device: start, d0..d7, parity, stop
        bit          ack;
        int          glitch;    // falling edge number preceded by a short clock glitch, 0 = none
        bit          dup;       // pulse a second start with other data while busy
        int          exp_done;
        int          exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;
    int   n_err  = 0;
    int   n_both = 0;
    logic [10:0] sb_q[$];
    vec_t tbl[7];

    ps2_transmitter_if bus();

    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe  | dev_clk_low);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_dat_low);

    ps2_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) n_done++;
        if (bus.error === 1'b1) n_err++;
        if (bus.done === 1'b1 && bus.error === 1'b1) n_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Device side: sample start bit, clock 10 more bits sampling at rising edges, then ACK.
    task automatic device(input bit ack, input int glitch, output logic [10:0] rx, output bit busy_ok);
        int n;
        rx = '0;
        busy_ok = 1'b1;
        n = 0;
        while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_data_oe == 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", longint'(n < 5000), 1);
        repeat (HALF) @(negedge clk);
        rx[0] = bus.ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            if (i == glitch) begin
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            rx[i] = bus.ps2_data_in;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (ack) dev_dat_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [10:0] rx;
        logic [10:0] expf;
        bit bok;
        int n, k, d0, e0;
        d0 = n_done;
        e0 = n_err;
        bus.tx_data = v.data;
        bus.start   = 1'b1;
        sb_q.push_back(v.frame);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        n = 0;
        k = 0;
        while (!bus.ps2_data_oe && k < INH + 100) begin
            if (bus.ps2_clk_oe) n++;
            if (v.dup && k == 3) begin
                bus.start   = 1'b1;
                bus.tx_data = 8'hC3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check("inhibit_len", n, INH);
        device(v.ack, v.glitch, rx, bok);
        check("busy_during_frame", bok, 1);
        k = 0;
        while (bus.busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("busy_release", bus.busy, 0);
        repeat (2) @(negedge clk);
        expf = sb_q.pop_front();
        check("frame_bits", rx, expf);
        check("done_count", n_done - d0, v.exp_done);
        check("error_count", n_err - e0, v.exp_err);
        check("oe_idle", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
        if (v.dup) begin
            n = 0;
            repeat (300) begin
                @(negedge clk);
                if (bus.busy) n++;
            end
            check("dup_start_ignored", n, 0);
        end
    endtask

    initial begin
        int n, k, d0, e0;
        vec_t post;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;

        tbl[0] = '{8'hFF, 11'h7FE, 1'b1, 0, 1'b0, 1, 0};
        tbl[1] = '{8'hED, 11'h7DA, 1'b1, 0, 1'b0, 1, 0};
        tbl[2] = '{8'h00, 11'h600, 1'b1, 0, 1'b0, 1, 0};
        tbl[3] = '{8'h01, 11'h402, 1'b1, 0, 1'b0, 1, 0};
        tbl[4] = '{8'hA5, 11'h74A, 1'b1, 5, 1'b0, 1, 0};
        tbl[5] = '{8'h3C, 11'h678, 1'b0, 0, 1'b0, 0, 1};
        tbl[6] = '{8'h5A, 11'h6B4, 1'b1, 0, 1'b1, 1, 0};
        post   = '{8'h96, 11'h72C, 1'b1, 0, 1'b0, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_clk_oe", bus.ps2_clk_oe, 0);
        check("reset_data_oe", bus.ps2_data_oe, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_error", bus.error, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i]);
            repeat (20) @(negedge clk);
        end

        // Device never clocks: error exactly TOUT cycles after the request-to-send.
        d0 = n_done;
        bus.tx_data = 8'h55;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.ps2_data_oe && k < INH + 100) begin
            @(negedge clk);
            k++;
        end
        n = 0;
        while (!bus.error && n < TOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TOUT);
        check("timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
        check("timeout_busy", bus.busy, 0);
        check("timeout_no_done", n_done - d0, 0);
        @(negedge clk);
        check("timeout_error_width", bus.error, 0);
        repeat (20) @(negedge clk);

        // Reset asserted mid-frame while bit 3 (a zero) is driven.
        d0 = n_done;
        e0 = n_err;
        bus.tx_data = 8'h96;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_data_oe == 1'b1) && k < INH + 100) begin
            @(negedge clk);
            k++;
        end
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        check("pre_reset_data_oe", bus.ps2_data_oe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
        check("async_reset_busy", bus.busy, 0);
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_no_done", n_done - d0, 0);
        check("reset_no_error", n_err - e0, 0);
        run_vec(post);

        check("scoreboard_empty", sb_q.size(), 0);
        check("done_error_exclusive", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
